mem_arbiter: RTL and testbench

- Sequences the single-ported RAM between the pipeline's instruction-fetch port and data-memory port.
- Sits below datapath_cache_if, between the fetch/memory stages and the RAM.
- Grants one access at a time. Data wins by default, and a starvation counter bounds how long fetch can be locked out.
- Returns per-port hit pulses and load data that the pipeline latches use as enables.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch and data memory.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_next;
  logic             w_dreq;

  assign w_dreq = dREN | dWEN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    case (r_state)
      IDLE: begin
        if (w_dreq && iREN) begin
          // Counter sits at LIMIT when LIMIT is 0, so this never forces fetch then.
          if ((STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT)) begin
            w_state_next  = IACC;
            w_starve_next = '0;
          end else begin
            w_state_next = DACC;
            if (r_starve_cnt != LIMIT) w_starve_next = r_starve_cnt + CNT_W'(1);
          end
        end else if (w_dreq) begin
          w_state_next  = DACC;
          w_starve_next = '0;
        end else if (iREN) begin
          w_state_next  = IACC;
          w_starve_next = '0;
        end
      end
      IACC: if (!iREN || ram_ready) w_state_next = IDLE;
      DACC: if (!w_dreq || ram_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    case (r_state)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        ihit    = ram_ready & iREN;
        if (ram_ready && iREN) iload = ramload;
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        dhit     = ram_ready & w_dreq;
        // A write wins when both dREN and dWEN are high; writes return no load data.
        if (dWEN) begin
          ramWEN = 1'b1;
        end else begin
          ramREN = 1'b1;
          if (ram_ready && dREN) dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level memory model and the data/fetch grant pattern.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  logic        use_model, mem_init;
  logic [31:0] ramload_drv;
  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Behavioural RAM used by the randomized run.
  assign ramload = use_model ? ram_mem[ramaddr[5:2]] : ramload_drv;
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
    end else if (use_model && ramWEN && ram_ready) begin
      ram_mem[ramaddr[5:2]] <= ramstore;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload_drv = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    clear_inputs();
    tick();
    tick();
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1; iREN = 1; dREN = 1; dWEN = 0; ram_ready = 1;
    iaddr = 32'h40; daddr = 32'h200; dstore = 32'h55; ramload_drv = 32'h1234_5678;
    tick();
    tick();
    #1;
    checks++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000", {ramREN, ramWEN, ihit, dhit});
    end
    checks++;
    if ({ramaddr, ramstore, iload, dload} !== 128'b0) begin
      errors++;
      $display("FAIL reset_buses: got addr=%h store=%h iload=%h dload=%h want all 0",
               ramaddr, ramstore, iload, dload);
    end
    RST = 0;
    tick();
    #1;
    checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200) begin
      errors++;
      $display("FAIL reset_first_grant: got ren=%b wen=%b addr=%h want ren=1 wen=0 addr=200",
               ramREN, ramWEN, ramaddr);
    end
    checks++;
    if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_first_hit: got dhit=%b ihit=%b dload=%h want 1 0 12345678",
               dhit, ihit, dload);
    end
    tick();
    iREN = 0; dREN = 0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || dhit !== 1'b0) begin
      errors++;
      $display("FAIL reset_bubble: got ren=%b dhit=%b want 0 0", ramREN, dhit);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    iREN = 1; iaddr = 32'h40; ram_ready = 0; ramload_drv = 32'h8C22_0004;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait%0d: got ren=%b addr=%h ihit=%b want 1 40 0",
                 k, ramREN, ramaddr, ihit);
      end
      tick();
    end
    ram_ready = 1;
    #1;
    checks++;
    if (ihit !== 1'b1 || iload !== 32'h8C22_0004) begin
      errors++;
      $display("FAIL fetch_hit: got ihit=%b iload=%h want 1 8c220004", ihit, iload);
    end
    tick();
    #1;
    checks++;
    if (ihit !== 1'b0 || ramREN !== 1'b0 || iload !== 32'h0) begin
      errors++;
      $display("FAIL fetch_after: got ihit=%b ren=%b iload=%h want 0 0 0", ihit, ramREN, iload);
    end
    iREN = 0; ram_ready = 0;
    tick();
  endtask

  task automatic test_write();
    do_reset();
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ram_ready = 0; ramload_drv = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 ||
          ramstore !== 32'hDEAD_BEEF || dhit !== 1'b0) begin
        errors++;
        $display("FAIL write_wait%0d: got wen=%b ren=%b addr=%h store=%h dhit=%b want 1 0 100 deadbeef 0",
                 k, ramWEN, ramREN, ramaddr, ramstore, dhit);
      end
      tick();
    end
    ram_ready = 1;
    #1;
    checks++;
    if (dhit !== 1'b1 || dload !== 32'h0) begin
      errors++;
      $display("FAIL write_hit: got dhit=%b dload=%h want 1 0", dhit, dload);
    end
    tick();
    dWEN = 0; ram_ready = 0;
    #1;
    checks++;
    if (ramWEN !== 1'b0 || dhit !== 1'b0) begin
      errors++;
      $display("FAIL write_after: got wen=%b dhit=%b want 0 0", ramWEN, dhit);
    end
  endtask

  task automatic test_starvation();
    int grants;
    int last_hit;
    logic exp_i;
    do_reset();
    iREN = 1; dREN = 1; ram_ready = 1;
    iaddr = 32'h0; daddr = 32'h800; ramload_drv = $urandom;
    grants = 0;
    last_hit = 0;
    for (int cyc = 1; cyc <= 100 && grants < 6; cyc++) begin
      tick();
      #1;
      if (ihit || dhit) begin
        exp_i = ((grants % (LIM + 1)) == LIM);
        checks++;
        if (ihit !== exp_i || dhit !== !exp_i) begin
          errors++;
          $display("FAIL starve_order%0d: got ihit=%b dhit=%b want ihit=%b", grants, ihit, dhit, exp_i);
        end
        checks++;
        if ((exp_i ? iload : dload) !== ramload_drv) begin
          errors++;
          $display("FAIL starve_load%0d: got %h want %h", grants, exp_i ? iload : dload, ramload_drv);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_hit != 2) begin
            errors++;
            $display("FAIL starve_spacing%0d: got %0d cycles want 2", grants, cyc - last_hit);
          end
        end
        $display("starve grant %0d: %s", grants, ihit ? "I" : "D");
        last_hit = cyc;
        grants++;
        iaddr = iaddr + 4;
        daddr = daddr + 4;
        ramload_drv = $urandom;
      end
    end
    checks++;
    if (grants != 6) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants want 6", grants);
    end
    iREN = 0; dREN = 0; ram_ready = 0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    iREN = 1; iaddr = 32'h80; ram_ready = 0; ramload_drv = 32'hCAFE_F00D;
    tick();
    #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
      errors++;
      $display("FAIL abort_grant: got ren=%b addr=%h want 1 80", ramREN, ramaddr);
    end
    iREN = 0; ram_ready = 1;
    #1;
    checks++;
    if (ihit !== 1'b0 || iload !== 32'h0) begin
      errors++;
      $display("FAIL abort_nohit: got ihit=%b iload=%h want 0 0", ihit, iload);
    end
    tick();
    #1;
    checks++;
    if (ramREN !== 1'b0 || ihit !== 1'b0 || ramaddr !== 32'h0) begin
      errors++;
      $display("FAIL abort_idle: got ren=%b ihit=%b addr=%h want 0 0 0", ramREN, ihit, ramaddr);
    end
    ram_ready = 0;
  endtask

  task automatic test_mid_reset();
    int dhits;
    do_reset();
    iREN = 1; dWEN = 1; daddr = 32'h100; dstore = $urandom; ram_ready = 1;
    dhits = 0;
    for (int cyc = 0; cyc < 40 && dhits < 3; cyc++) begin
      tick();
      #1;
      if (ihit) begin
        checks++;
        errors++;
        $display("FAIL midrst_prefetch: got ihit=1 want 0 before starvation limit");
      end
      if (dhit) dhits++;
    end
    checks++;
    if (dhits != 3) begin
      errors++;
      $display("FAIL midrst_setup: got %0d data hits want 3", dhits);
    end
    tick();
    ram_ready = 0;
    tick();
    #1;
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL midrst_inwrite: got wen=%b ren=%b want 1 0", ramWEN, ramREN);
    end
    RST = 1;
    tick();
    RST = 0;
    #1;
    checks++;
    if (ramWEN !== 1'b0 || dhit !== 1'b0 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got wen=%b ren=%b dhit=%b want 0 0 0", ramWEN, ramREN, dhit);
    end
    ram_ready = 1;
    tick();
    #1;
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || dhit !== 1'b1 || ihit !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regrant: got wen=%b ren=%b dhit=%b ihit=%b want data grant 1 0 1 0",
               ramWEN, ramREN, dhit, ihit);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic new_data_req();
    logic wr;
    wr = 1'($urandom_range(0, 1));
    dWEN = wr;
    dREN = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
    daddr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
    dstore = $urandom;
  endtask

  task automatic test_random();
    int grants;
    int wait_cyc;
    logic exp_i;
    logic got_hit;
    do_reset();
    use_model = 1;
    mem_init = 1;
    tick();
    mem_init = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    iREN = 1;
    iaddr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
    new_data_req();
    grants = 0;
    wait_cyc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ram_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (ramREN && ramWEN) begin
        errors++;
        $display("FAIL rand_strobes: cycle %0d got ren=1 wen=1 want never both", cyc);
      end
      got_hit = ihit | dhit;
      if (got_hit) begin
        exp_i = ((grants % (LIM + 1)) == LIM);
        checks++;
        if (ihit !== exp_i || dhit !== !exp_i) begin
          errors++;
          $display("FAIL rand_order%0d: got ihit=%b dhit=%b want ihit=%b", grants, ihit, dhit, exp_i);
        end
        if (ihit) begin
          checks++;
          if (iload !== ref_mem[iaddr[5:2]]) begin
            errors++;
            $display("FAIL rand_iload%0d: got %h want %h", grants, iload, ref_mem[iaddr[5:2]]);
          end
          $display("txn %0d: I read  addr=%h data=%h", grants, iaddr, iload);
        end else if (dWEN) begin
          ref_mem[daddr[5:2]] = dstore;
          $display("txn %0d: D write addr=%h data=%h", grants, daddr, dstore);
        end else begin
          checks++;
          if (dload !== ref_mem[daddr[5:2]]) begin
            errors++;
            $display("FAIL rand_dload%0d: got %h want %h", grants, dload, ref_mem[daddr[5:2]]);
          end
          $display("txn %0d: D read  addr=%h data=%h", grants, daddr, dload);
        end
      end
      tick();
      if (got_hit) begin
        if (exp_i) iaddr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        else new_data_req();
        grants++;
        wait_cyc = 0;
      end else begin
        wait_cyc++;
        if (wait_cyc > 60) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout: no hit for %0d cycles want at most 60", wait_cyc);
          break;
        end
      end
    end
    checks++;
    if (grants < 50) begin
      errors++;
      $display("FAIL rand_progress: got %0d grants want at least 50", grants);
    end
    use_model = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; use_model = 0; mem_init = 0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_write();
    test_starvation();
    test_abort();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
